// File: rtl/dot_map_scanner.sv
// dot_map_scanner
// Scans a ROWS x COLS dot map stored in a synchronous row memory (1-cycle read
// latency), one row per cycle, and accumulates the number of eaten dots.
// A scan takes ROWS+2 clocks from the accepted start to the done pulse.
// count/level_clr are updated only when a scan completes and otherwise hold
// their value, so the score logic can read them at any time.
// The FIN state is the single cycle in which done is high. It accepts a new
// start exactly like IDLE, which lets scans run back to back.

module dot_map_scanner #(
  parameter int COLS   = 12,
  parameter int ROWS   = 16,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic              abort,
  output logic              row_rd,
  output logic [ADDR_W-1:0] row_addr,
  input  logic [COLS-1:0]   row_data,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic              level_clr
);

  // Elaboration-time checks on the parameter set
  if (2**CNT_W <= ROWS*COLS) begin : g_cnt_w_check
    $error("dot_map_scanner: CNT_W too small to hold ROWS*COLS");
  end
  if (2**ADDR_W < ROWS) begin : g_addr_w_check
    $error("dot_map_scanner: ADDR_W too small to address ROWS rows");
  end

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(ROWS - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(ROWS * COLS);

  // Number of set bits in one row, zero-extended to the count width
  function automatic logic [CNT_W-1:0] popcount(input logic [COLS-1:0] v);
    logic [CNT_W-1:0] n;
    n = {CNT_W{1'b0}};
    for (int i = 0; i < COLS; i++) begin
      n = n + CNT_W'(v[i]);
    end
    return n;
  endfunction

  logic [1:0]        r_state;
  logic              r_rd_d;      // row_rd delayed: row_data is valid this cycle
  logic [CNT_W-1:0]  r_acc;
  logic              r_row_rd;
  logic [ADDR_W-1:0] r_row_addr;
  logic              r_busy;
  logic              r_done;
  logic [CNT_W-1:0]  r_count;
  logic              r_level_clr;

  logic [CNT_W-1:0]  w_acc_sum;

  assign w_acc_sum = r_acc + popcount(row_data);

  assign row_rd    = r_row_rd;
  assign row_addr  = r_row_addr;
  assign busy      = r_busy;
  assign done      = r_done;
  assign count     = r_count;
  assign level_clr = r_level_clr;

  // Scan sequencer, row accumulator and registered result outputs
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= S_IDLE;
      r_rd_d      <= 1'b0;
      r_acc       <= {CNT_W{1'b0}};
      r_row_rd    <= 1'b0;
      r_row_addr  <= {ADDR_W{1'b0}};
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_count     <= {CNT_W{1'b0}};
      r_level_clr <= 1'b0;
    end else begin
      r_rd_d <= r_row_rd;
      r_done <= 1'b0;
      // Absorb the row returned for the previous cycle's read
      if (r_rd_d) begin
        r_acc <= w_acc_sum;
      end else begin
        r_acc <= r_acc;
      end

      case (r_state)
        S_IDLE, S_FIN: begin
          if (abort) begin
            r_state <= S_IDLE;
          end else if (start) begin
            r_state    <= S_SCAN;
            r_acc      <= {CNT_W{1'b0}};
            r_row_addr <= {ADDR_W{1'b0}};
            r_row_rd   <= 1'b1;
            r_busy     <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_SCAN: begin
          if (abort) begin
            r_state  <= S_IDLE;
            r_row_rd <= 1'b0;
            r_busy   <= 1'b0;
          end else if (r_row_addr == LAST_ROW) begin
            r_state  <= S_DRAIN;
            r_row_rd <= 1'b0;
          end else begin
            r_row_addr <= r_row_addr + ADDR_W'(1);
          end
        end
        S_DRAIN: begin
          // Last row's data is on row_data now; publish the completed total
          if (abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state     <= S_FIN;
            r_count     <= w_acc_sum;
            r_level_clr <= (w_acc_sum == FULL_CNT);
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_row_rd <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dot_map_scanner.sv
// Self-checking bench for dot_map_scanner: a behavioural row memory feeds the
// DUT, and expected totals come from summing set bits over the stored map.

module tb_dot_map_scanner;

  localparam int ROWS   = 16;
  localparam int COLS   = 12;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 8;
  localparam int LAT    = ROWS + 2;

  logic              Clk = 1'b0;
  logic              Reset_n;
  logic              start;
  logic              abort;
  logic              row_rd;
  logic [ADDR_W-1:0] row_addr;
  logic [COLS-1:0]   row_data;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  count;
  logic              level_clr;

  logic [COLS-1:0] mem [0:ROWS-1];
  int total = 0;
  int bad   = 0;

  dot_map_scanner #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .abort(abort),
    .row_rd(row_rd), .row_addr(row_addr), .row_data(row_data),
    .busy(busy), .done(done), .count(count), .level_clr(level_clr)
  );

  always #5 Clk = ~Clk;

  // Row memory: one-cycle read latency, junk on the bus when not read
  always @(posedge Clk) begin
    if (row_rd) row_data <= mem[row_addr];
    else        row_data <= COLS'($urandom);
  end

  function automatic int model_count();
    int s = 0;
    for (int r = 0; r < ROWS; r++) s += $countones(mem[r]);
    return s;
  endfunction

  // Pulse start for one cycle; when now=1 the caller is already at a negedge
  task automatic start_pulse(input bit now);
    if (!now) @(negedge Clk);
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
  endtask

  // Launch a scan, wait for done, check latency, result and (optionally) addresses
  task automatic scan_and_check(input string name, input bit chk_addr, input bit b2b);
    int cyc;
    bit got;
    int exp_cnt;
    bit exp_lvl;
    logic [ADDR_W-1:0] addrs[$];
    exp_cnt = model_count();
    exp_lvl = (exp_cnt == ROWS * COLS);
    start_pulse(b2b);
    cyc = 1;
    got = 1'b0;
    while (cyc < 3 * LAT) begin
      if (row_rd) addrs.push_back(row_addr);
      if (done) begin
        got = 1'b1;
        break;
      end
      @(negedge Clk);
      cyc++;
    end
    total++;
    if (!got || cyc != LAT) begin
      bad++;
      $display("FAIL %s latency: got %0d (done seen=%0d) expected %0d", name, cyc, got, LAT);
    end
    total++;
    if (count !== CNT_W'(exp_cnt)) begin
      bad++;
      $display("FAIL %s count: got %0d expected %0d", name, count, exp_cnt);
    end
    total++;
    if (level_clr !== exp_lvl) begin
      bad++;
      $display("FAIL %s level_clr: got %0b expected %0b", name, level_clr, exp_lvl);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s busy_at_done: got %0b expected 0", name, busy);
    end
    if (chk_addr) begin
      bit ok = (addrs.size() == ROWS);
      for (int i = 0; i < addrs.size(); i++) if (addrs[i] !== ADDR_W'(i)) ok = 1'b0;
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL %s addr_seq: got %0d reads expected %0d in order 0..%0d",
                 name, addrs.size(), ROWS, ROWS - 1);
      end
    end
  endtask

  // Watch n cycles and return how many done pulses were seen
  task automatic count_dones(input int n, output int seen);
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      if (done) seen++;
    end
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    for (int r = 0; r < ROWS; r++) mem[r] = '0;
    repeat (2) @(negedge Clk);
    total++;
    if ({row_rd, busy, done, level_clr} !== 4'b0000 || count !== '0 || row_addr !== '0) begin
      bad++;
      $display("FAIL reset_values: got rd=%0b busy=%0b done=%0b lvl=%0b cnt=%0d addr=%0d expected all 0",
               row_rd, busy, done, level_clr, count, row_addr);
    end
    Reset_n = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_empty();
    for (int r = 0; r < ROWS; r++) mem[r] = '0;
    scan_and_check("empty", 1'b0, 1'b0);
  endtask

  task automatic test_ramp();
    for (int r = 0; r < ROWS; r++) mem[r] = (r < COLS) ? COLS'((1 << (r + 1)) - 1) : {COLS{1'b1}};
    scan_and_check("ramp", 1'b1, 1'b0);
  endtask

  task automatic test_full_back_to_back();
    for (int r = 0; r < ROWS; r++) mem[r] = {COLS{1'b1}};
    scan_and_check("full", 1'b0, 1'b0);
    mem[5][3] = 1'b0;
    scan_and_check("full_minus1_b2b", 1'b0, 1'b1);
  endtask

  task automatic test_abort();
    int seen;
    int guard;
    for (int r = 0; r < ROWS; r++) mem[r] = '0;
    for (int r = 0; r < 4; r++) mem[r] = {COLS{1'b1}};
    mem[4] = COLS'(3);
    scan_and_check("prior50", 1'b0, 1'b0);
    for (int r = 0; r < ROWS; r++) mem[r] = COLS'($urandom);
    start_pulse(1'b0);
    guard = 0;
    while (!(row_rd && row_addr == ADDR_W'(7)) && guard < 3 * LAT) begin
      @(negedge Clk);
      guard++;
    end
    abort = 1'b1;
    @(negedge Clk);
    abort = 1'b0;
    total++;
    if (busy !== 1'b0 || row_rd !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL abort_stop: got busy=%0b rd=%0b done=%0b expected 0 0 0", busy, row_rd, done);
    end
    count_dones(2 * LAT, seen);
    total++;
    if (seen != 0 || count !== CNT_W'(50)) begin
      bad++;
      $display("FAIL abort_hold: got dones=%0d count=%0d expected 0 and 50", seen, count);
    end
    start = 1'b1;
    abort = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    abort = 1'b0;
    total++;
    if (busy !== 1'b0 || row_rd !== 1'b0) begin
      bad++;
      $display("FAIL abort_wins_idle: got busy=%0b rd=%0b expected 0 0", busy, row_rd);
    end
    scan_and_check("after_abort", 1'b0, 1'b0);
  endtask

  task automatic test_start_while_busy();
    int seen;
    int dcyc;
    int exp_cnt;
    for (int r = 0; r < ROWS; r++) mem[r] = COLS'($urandom);
    exp_cnt = model_count();
    seen = 0;
    dcyc = 0;
    start_pulse(1'b0);
    for (int c = 1; c < 3 * LAT; c++) begin
      if (done) begin
        seen++;
        dcyc = c;
      end
      start = (c >= 2 && c <= ROWS && (c % 2) == 0);
      @(negedge Clk);
      start = 1'b0;
    end
    total++;
    if (seen != 1 || dcyc != LAT) begin
      bad++;
      $display("FAIL busy_start_dones: got %0d dones (last at %0d) expected 1 at %0d", seen, dcyc, LAT);
    end
    total++;
    if (count !== CNT_W'(exp_cnt)) begin
      bad++;
      $display("FAIL busy_start_count: got %0d expected %0d", count, exp_cnt);
    end
  endtask

  task automatic test_reset_mid_scan();
    int seen;
    for (int r = 0; r < ROWS; r++) mem[r] = COLS'($urandom) | COLS'(1);
    start_pulse(1'b0);
    repeat (5) @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || row_rd !== 1'b0 || done !== 1'b0 || count !== '0 || level_clr !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_scan: got busy=%0b rd=%0b done=%0b cnt=%0d lvl=%0b expected all 0",
               busy, row_rd, done, count, level_clr);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    count_dones(2 * LAT, seen);
    total++;
    if (seen != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_no_done: got dones=%0d busy=%0b expected 0 0", seen, busy);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      for (int r = 0; r < ROWS; r++) mem[r] = COLS'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        for (int r = 0; r < ROWS; r++) mem[r] = {COLS{1'b1}};
      end
      scan_and_check($sformatf("random%0d", it), 1'b1, (it % 2) == 1);
    end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_ramp();
    test_full_back_to_back();
    test_abort();
    test_start_while_busy();
    test_reset_mid_scan();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
